// File: rtl/cordic_rotation_engine_if.sv
// Handshake and result bundle for cordic_rotation_engine.
// The master side issues requests and hosts the combinational angle ROM.
// The slave side is the engine itself.
interface cordic_rotation_engine_if #(
  parameter int FIXED_WIDTH = 16,
  parameter int ITERATIONS  = 9
);
  localparam int IDX_W = $clog2(ITERATIONS);

  logic                          start;
  logic signed [FIXED_WIDTH-1:0] angle_in;
  logic        [IDX_W-1:0]       rom_idx;
  logic signed [FIXED_WIDTH-1:0] rom_angle;
  logic signed [FIXED_WIDTH-1:0] cos_out;
  logic signed [FIXED_WIDTH-1:0] sin_out;
  logic                          busy;
  logic                          done;

  modport master (
    output start, angle_in, rom_angle,
    input  rom_idx, cos_out, sin_out, busy, done
  );

  modport slave (
    input  start, angle_in, rom_angle,
    output rom_idx, cos_out, sin_out, busy, done
  );
endinterface

// File: rtl/cordic_rotation_engine.sv
// Iterative rotation-mode CORDIC that computes cos/sin of a signed 2.14 angle.
// It performs one micro-rotation per clock, and the atan table lives outside the block.
// Optional macro CORDIC_QUADRANT_FOLD_EN folds angles beyond +/-pi/2 into the
// convergence range. The results are then negated.
module cordic_rotation_engine #(
  parameter int FIXED_WIDTH = 16,
  parameter int ITERATIONS  = 9
) (
  input logic                    clk,
  input logic                    rst_n,
  cordic_rotation_engine_if.slave bus
);
  localparam int IDX_W = $clog2(ITERATIONS);
  localparam int XW    = FIXED_WIDTH + 2;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(ITERATIONS - 1);
  localparam logic signed [XW-1:0] K_INIT   = XW'(9949);
  localparam logic signed [XW-1:0] SAT_MAX  = XW'((2 ** (FIXED_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN  = XW'(-(2 ** (FIXED_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        counter_r;
  logic signed [XW-1:0]    x_r, y_r, z_r;
  logic signed [FIXED_WIDTH-1:0] cos_r, sin_r;
  logic                    busy_r, done_r;

  logic                    d_pos_s;
  logic signed [XW-1:0]    x_sh_s, y_sh_s, rom_ext_s;
  logic signed [XW-1:0]    x_next_s, y_next_s, z_next_s;
  logic signed [XW-1:0]    z_load_s, cos_pre_s, sin_pre_s;

`ifdef CORDIC_QUADRANT_FOLD_EN
  localparam logic signed [XW-1:0] FOLD_HI   = XW'(25736);
  localparam logic signed [XW-1:0] FOLD_LO   = XW'(-25736);
  localparam logic signed [XW-1:0] FOLD_SPAN = XW'(51472);
  logic                    fold_r;
  logic                    fold_load_s;
  logic signed [XW-1:0]    angle_ext_s;
`endif

  // Clamp a wide intermediate into the signed output range.
  function automatic logic signed [FIXED_WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[FIXED_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[FIXED_WIDTH-1:0];
    end else begin
      return v[FIXED_WIDTH-1:0];
    end
  endfunction

  // Single micro-rotation datapath driven by the current z sign and iteration index.
  always_comb begin
    d_pos_s   = ~z_r[XW-1];
    x_sh_s    = x_r >>> counter_r;
    y_sh_s    = y_r >>> counter_r;
    rom_ext_s = XW'(bus.rom_angle);
    if (d_pos_s) begin
      x_next_s = x_r - y_sh_s;
      y_next_s = y_r + x_sh_s;
      z_next_s = z_r - rom_ext_s;
    end else begin
      x_next_s = x_r + y_sh_s;
      y_next_s = y_r - x_sh_s;
      z_next_s = z_r + rom_ext_s;
    end
  end

`ifdef CORDIC_QUADRANT_FOLD_EN
  // Fold far angles back by pi and remember to flip the final vector.
  always_comb begin
    angle_ext_s = XW'(bus.angle_in);
    if (angle_ext_s > FOLD_HI) begin
      z_load_s    = angle_ext_s - FOLD_SPAN;
      fold_load_s = 1'b1;
    end else if (angle_ext_s < FOLD_LO) begin
      z_load_s    = angle_ext_s + FOLD_SPAN;
      fold_load_s = 1'b1;
    end else begin
      z_load_s    = angle_ext_s;
      fold_load_s = 1'b0;
    end
  end

  // Negate the final rotation result when the angle was folded.
  always_comb begin
    if (fold_r) begin
      cos_pre_s = -x_next_s;
      sin_pre_s = -y_next_s;
    end else begin
      cos_pre_s = x_next_s;
      sin_pre_s = y_next_s;
    end
  end

  // Fold flag is captured together with the operand load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fold_r <= 1'b0;
    end else if (state_r == IDLE && bus.start) begin
      fold_r <= fold_load_s;
    end else begin
      fold_r <= fold_r;
    end
  end
`else
  // Angle is used as-is; the final vector needs no correction.
  always_comb begin
    z_load_s  = XW'(bus.angle_in);
    cos_pre_s = x_next_s;
    sin_pre_s = y_next_s;
  end
`endif

  // Control FSM plus iteration registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      counter_r <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      cos_r     <= '0;
      sin_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            x_r       <= K_INIT;
            y_r       <= '0;
            z_r       <= z_load_s;
            counter_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          x_r <= x_next_s;
          y_r <= y_next_s;
          z_r <= z_next_s;
          if (counter_r == LAST_IDX) begin
            counter_r <= '0;
            cos_r     <= sat(cos_pre_s);
            sin_r     <= sat(sin_pre_s);
            done_r    <= 1'b1;
            state_r   <= DONE;
          end else begin
            counter_r <= counter_r + IDX_W'(1);
            state_r   <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          counter_r <= '0;
          done_r    <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.rom_idx = counter_r;
  assign bus.cos_out = cos_r;
  assign bus.sin_out = sin_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Self-checking bench for cordic_rotation_engine: vector table, random angles
// against a real-arithmetic cos/sin model, and hand-written timing sequences.
module tb_cordic_rotation_engine;
  localparam int W   = 16;
  localparam int IT  = 9;
  localparam int TOL = 100;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  cordic_rotation_engine_if #(.FIXED_WIDTH(W), .ITERATIONS(IT)) bus ();

  cordic_rotation_engine #(.FIXED_WIDTH(W), .ITERATIONS(IT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // atan(2^-i) in 2.14, rounded
  function automatic logic signed [W-1:0] atan_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'sd12868;
      4'd1:    return 16'sd7596;
      4'd2:    return 16'sd4014;
      4'd3:    return 16'sd2037;
      4'd4:    return 16'sd1023;
      4'd5:    return 16'sd512;
      4'd6:    return 16'sd256;
      4'd7:    return 16'sd128;
      4'd8:    return 16'sd64;
      default: return 16'sd0;
    endcase
  endfunction

  assign bus.rom_angle = atan_rom(bus.rom_idx);

  typedef struct {
    int angle;
    int exp_cos;
    int exp_sin;
  } vec_t;

  task automatic check(input string name, input int got, input int exp, input int tol);
    checks++;
    if (got - exp > tol || exp - got > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, got, exp, tol);
    end
  endtask

  // Start one computation and follow it to completion.
  task automatic apply(input int angle, output int c, output int s, output int lat,
                       output int busy_cyc, output int proto_err);
    @(negedge clk);
    bus.angle_in = 16'(angle);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 0;
    busy_cyc  = bus.busy ? 1 : 0;
    proto_err = (bus.rom_idx != 4'd0) ? 1 : 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cyc++;
      if (!bus.done && bus.rom_idx != 4'(lat)) proto_err++;
      if (bus.done && bus.rom_idx != 4'd0) proto_err++;
    end
    c = bus.cos_out;
    s = bus.sin_out;
    for (int k = 0; k < 6 && bus.busy; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) proto_err++;
    end
  endtask

  function automatic int model_cos(input int angle);
    real a;
    a = real'(angle) / 16384.0;
    return int'(16384.0 * $cos(a));
  endfunction

  function automatic int model_sin(input int angle);
    real a;
    a = real'(angle) / 16384.0;
    return int'(16384.0 * $sin(a));
  endfunction

  // Abort guard so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Main stimulus and checking sequence.
  initial begin
    vec_t vecs[$];
    int c, s, lat, bcyc, perr, ang, dcount, first, second, prev_c, prev_s;

    vecs.push_back('{0,      16384, 0});
    vecs.push_back('{12868,  11585, 11585});
    vecs.push_back('{-8579,  14189, -8192});
    vecs.push_back('{-12868, 11585, -11585});
    vecs.push_back('{25736,  0,     16384});
    vecs.push_back('{-25736, 0,     -16384});
`ifdef CORDIC_QUADRANT_FOLD_EN
    vecs.push_back('{31130,  -5297, 15505});
    vecs.push_back('{-31130, -5297, -15505});
`endif

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.angle_in = '0;
    repeat (3) @(negedge clk);
    check("reset_cos", int'(bus.cos_out), 0, 0);
    check("reset_sin", int'(bus.sin_out), 0, 0);
    check("reset_flags", int'({bus.busy, bus.done, bus.rom_idx}), 0, 0);
    rst_n = 1'b1;

    // Table-driven vectors
    foreach (vecs[i]) begin
      apply(vecs[i].angle, c, s, lat, bcyc, perr);
      check($sformatf("vec%0d_cos", i), c, vecs[i].exp_cos, TOL);
      check($sformatf("vec%0d_sin", i), s, vecs[i].exp_sin, TOL);
      check($sformatf("vec%0d_latency", i), lat, IT, 0);
      check($sformatf("vec%0d_busy_cycles", i), bcyc, IT + 1, 0);
      check($sformatf("vec%0d_protocol", i), perr, 0, 0);
    end

    // Random angles against the real-arithmetic model
    for (int r = 0; r < 16; r++) begin
`ifdef CORDIC_QUADRANT_FOLD_EN
      ang = int'($urandom_range(65535, 0)) - 32768;
`else
      ang = int'($urandom_range(50000, 0)) - 25000;
`endif
      apply(ang, c, s, lat, bcyc, perr);
      check($sformatf("rand%0d_cos(a=%0d)", r, ang), c, model_cos(ang), TOL);
      check($sformatf("rand%0d_sin(a=%0d)", r, ang), s, model_sin(ang), TOL);
      check($sformatf("rand%0d_latency", r), lat, IT, 0);
    end

    // Outputs hold while idle even as angle_in wanders
    prev_c = bus.cos_out;
    prev_s = bus.sin_out;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.angle_in = 16'($urandom);
    end
    check("hold_cos", int'(bus.cos_out), prev_c, 0);
    check("hold_sin", int'(bus.sin_out), prev_s, 0);

    // Second start during RUN cycle 3 is ignored
    @(negedge clk);
    bus.angle_in = 16'sd12868;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.angle_in = -16'sd8579;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.angle_in = '0;
    dcount = 0;
    c = 0;
    s = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done) begin
        dcount++;
        c = bus.cos_out;
        s = bus.sin_out;
      end
      @(negedge clk);
    end
    check("ignore_start_done_count", dcount, 1, 0);
    check("ignore_start_cos", c, 11585, TOL);
    check("ignore_start_sin", s, 11585, TOL);

    // Reset asserted at RUN cycle 4 clears everything at once
    @(negedge clk);
    bus.angle_in = '0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_cos", int'(bus.cos_out), 0, 0);
    check("midrun_reset_sin", int'(bus.sin_out), 0, 0);
    check("midrun_reset_flags", int'({bus.busy, bus.done, bus.rom_idx}), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(-8579, c, s, lat, bcyc, perr);
    check("after_reset_cos", c, 14189, TOL);
    check("after_reset_sin", s, -8192, TOL);
    check("after_reset_latency", lat, IT, 0);

    // Start held high restarts on the first IDLE cycle after DONE
    @(negedge clk);
    bus.angle_in = 16'sd12868;
    bus.start    = 1'b1;
    first  = -1;
    second = -1;
    dcount = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dcount++;
        if (first < 0) begin
          first = k;
        end else if (second < 0) begin
          second = k;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("held_start_first_done", first, IT + 1, 0);
    check("held_start_interval", second - first, IT + 2, 0);
    check("held_start_done_count", dcount, 2, 0);
    check("held_start_cos", int'(bus.cos_out), 11585, TOL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
